// File: rtl/inst_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the instruction fetch queue and its consumers.
// The entry layout macros (the fetch_defs set) live here so decode can
// unpack queue entries with the same bit offsets. Package-level localparams
// and a packed struct mirror the macros for typed use inside the design.
// Ports: none (package).
// ---------------------------------------------------------------------------
`ifndef FETCH_DEFS_VH
`define FETCH_DEFS_VH
`define FQ_ENTRY_W  97
`define FQ_PC_LSB   0
`define FQ_INST_LSB 32
`define FQ_TGT_LSB  64
`define FQ_TKN_BIT  96
`endif

package inst_fetch_queue_pkg;

    localparam int FQ_ENTRY_W  = `FQ_ENTRY_W;
    localparam int FQ_PC_LSB   = `FQ_PC_LSB;
    localparam int FQ_INST_LSB = `FQ_INST_LSB;
    localparam int FQ_TGT_LSB  = `FQ_TGT_LSB;
    localparam int FQ_TKN_BIT  = `FQ_TKN_BIT;

    // Field order is MSB first, so the packed layout matches the offsets
    // above: pc [31:0], inst [63:32], target [95:64], taken [96].
    typedef struct packed {
        logic        tkn;
        logic [31:0] tgt;
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_regfile.sv
// ---------------------------------------------------------------------------
// fq_regfile
// DEPTH x W storage array for the fetch queue: one synchronous write port,
// two combinational read ports, asynchronous active-low reset to zero.
// Ports:
//   clk, resetn          clock / async active-low reset
//   i_we, i_waddr        write enable and index
//   i_wdata              packed entry to write
//   i_raddr0, i_raddr1   read indices (oldest / second-oldest)
//   o_rdata0, o_rdata1   combinational read data
// ---------------------------------------------------------------------------
module fq_regfile #(
    parameter int DEPTH = 8,
    parameter int W     = 97,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [PTR_W-1:0] i_raddr0,
    input  logic [PTR_W-1:0] i_raddr1,
    output logic [W-1:0]     o_rdata0,
    output logic [W-1:0]     o_rdata1
);

    logic [W-1:0] r_mem [DEPTH];

    // Clearing the array on reset keeps the read ports free of X even
    // while the matching valid is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
// Decoupling buffer between fetch/branch prediction and dual-issue decode.
// Accepts one predicted instruction per cycle, presents the two oldest
// entries, and lets decode retire 0, 1 or 2 per cycle. A flush empties
// the queue in one cycle.
// Ports:
//   clk, resetn                  clock / async active-low reset
//   flush                        drop all entries and same-cycle enq/deq
//   in_valid / in_ready          fetch handshake
//   in_pc, in_inst               instruction address and word
//   in_pred_taken, in_pred_target prediction for this instruction
//   out_valid0/1                 oldest / second-oldest entry present
//   out_pc*, out_inst*, out_pred_taken*, out_pred_target*  entry fields
//   deq_num                      entries consumed by decode (3 means 2)
//   count                        current occupancy
// ---------------------------------------------------------------------------
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_target,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_pred_target0,
    output logic             out_pred_taken0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_pred_target1,
    output logic             out_pred_taken1,
    input  logic [1:0]       deq_num,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    // Decode may ask for more than is present; the request is clamped to
    // two and then to the occupancy, so the head can never pass the tail.
    function automatic logic [PTR_W:0] clamp_deq(input logic [1:0]     req,
                                                 input logic [PTR_W:0] occ);
        logic [PTR_W:0] want;
        want = (req == 2'd3) ? (PTR_W+1)'(2) : (PTR_W+1)'(req);
        return (want > occ) ? occ : want;
    endfunction

    logic [PTR_W:0] r_head;
    logic [PTR_W:0] r_tail;
    logic [PTR_W:0] r_count;

    logic           w_enq;
    logic [PTR_W:0] w_deq_eff;
    logic [PTR_W:0] w_enq_ext;
    fq_entry_t      w_wr_entry;
    fq_entry_t      w_rd0;
    fq_entry_t      w_rd1;
    logic [PTR_W-1:0] w_raddr1;

    // Ready depends only on the registered occupancy: a full queue does
    // not accept even when decode drains in the same cycle.
    assign in_ready  = (r_count != DEPTH_C);
    assign w_enq     = in_valid & in_ready & ~flush;
    assign w_enq_ext = {{PTR_W{1'b0}}, w_enq};
    assign w_deq_eff = clamp_deq(deq_num, r_count);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq_eff;
            r_tail  <= r_tail + w_enq_ext;
            r_count <= r_count + w_enq_ext - w_deq_eff;
        end
    end

    assign w_wr_entry = '{tkn: in_pred_taken, tgt: in_pred_target,
                          inst: in_inst, pc: in_pc};

    // Second read index wraps naturally in PTR_W bits.
    assign w_raddr1 = r_head[PTR_W-1:0] + 1'b1;

    fq_regfile #(
        .DEPTH (DEPTH),
        .W     (FQ_ENTRY_W)
    ) u_regfile (
        .clk      (clk),
        .resetn   (resetn),
        .i_we     (w_enq),
        .i_waddr  (r_tail[PTR_W-1:0]),
        .i_wdata  (w_wr_entry),
        .i_raddr0 (r_head[PTR_W-1:0]),
        .i_raddr1 (w_raddr1),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    assign count            = r_count;
    assign out_valid0       = (r_count >= (PTR_W+1)'(1));
    assign out_valid1       = (r_count >= (PTR_W+1)'(2));
    assign out_pc0          = w_rd0.pc;
    assign out_inst0        = w_rd0.inst;
    assign out_pred_target0 = w_rd0.tgt;
    assign out_pred_taken0  = w_rd0.tkn;
    assign out_pc1          = w_rd1.pc;
    assign out_inst1        = w_rd1.inst;
    assign out_pred_target1 = w_rd1.tgt;
    assign out_pred_taken1  = w_rd1.tkn;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed bench for inst_fetch_queue (DEPTH = 8) with hand-computed
// expected values checked by immediate assertions.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        out_valid0;
    logic        out_valid1;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic [31:0] out_pred_target0;
    logic        out_pred_taken0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic [31:0] out_pred_target1;
    logic        out_pred_taken1;
    logic [1:0]  deq_num;
    logic [3:0]  count;

    int n_vec;
    int n_miscmp;

    inst_fetch_queue #(.DEPTH(8)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_inst          (in_inst),
        .in_pred_taken    (in_pred_taken),
        .in_pred_target   (in_pred_target),
        .out_valid0       (out_valid0),
        .out_valid1       (out_valid1),
        .out_pc0          (out_pc0),
        .out_inst0        (out_inst0),
        .out_pred_target0 (out_pred_target0),
        .out_pred_taken0  (out_pred_taken0),
        .out_pc1          (out_pc1),
        .out_inst1        (out_inst1),
        .out_pred_target1 (out_pred_target1),
        .out_pred_taken1  (out_pred_taken1),
        .deq_num          (deq_num),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscmp++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc);
        in_valid       = v;
        in_pc          = pc;
        in_inst        = 32'h0000_0013;
        in_pred_taken  = 1'b0;
        in_pred_target = pc + 32'd4;
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        resetn   = 1'b0;
        flush    = 1'b0;
        deq_num  = 2'd0;
        // Offer an entry while held in reset: it must not be written.
        set_in(1'b1, 32'hDEAD_BEE0);
        in_pred_taken = 1'b1;
        repeat (3) step();

        chk("rst_ready",  32'(in_ready),   32'd1);
        chk("rst_count",  32'(count),      32'd0);
        chk("rst_v0",     32'(out_valid0), 32'd0);
        chk("rst_v1",     32'(out_valid1), 32'd0);
        chk("rst_pc0",    out_pc0,          32'd0);
        chk("rst_inst0",  out_inst0,        32'd0);
        chk("rst_tgt0",   out_pred_target0, 32'd0);
        chk("rst_tkn0",   32'(out_pred_taken0), 32'd0);
        chk("rst_pc1",    out_pc1,          32'd0);
        chk("rst_tgt1",   out_pred_target1, 32'd0);

        set_in(1'b0, 32'd0);
        resetn = 1'b1;
        step();
        chk("idle_count", 32'(count),      32'd0);
        chk("idle_v0",    32'(out_valid0), 32'd0);

        // ---- Basic enqueue of three entries ----
        set_in(1'b1, 32'h100);
        step();
        chk("enq1_v0",  32'(out_valid0), 32'd1);
        chk("enq1_pc0", out_pc0,         32'h100);
        chk("enq1_v1",  32'(out_valid1), 32'd0);
        set_in(1'b1, 32'h104);
        step();
        set_in(1'b1, 32'h108);
        step();
        chk("enq3_count", 32'(count),      32'd3);
        chk("enq3_pc0",   out_pc0,          32'h100);
        chk("enq3_pc1",   out_pc1,          32'h104);
        chk("enq3_inst1", out_inst1,        32'h13);
        chk("enq3_tgt1",  out_pred_target1, 32'h108);

        // ---- Fill to DEPTH ----
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h10C + 32'(4 * i));
            step();
        end
        chk("full_count", 32'(count),    32'd8);
        chk("full_ready", 32'(in_ready), 32'd0);
        set_in(1'b1, 32'h900);
        step();
        chk("full_hold_count", 32'(count), 32'd8);
        deq_num = 2'd2;
        step();
        chk("full_deq_count", 32'(count),    32'd6);
        chk("full_deq_ready", 32'(in_ready), 32'd1);
        chk("full_deq_pc0",   out_pc0,       32'h108);
        deq_num = 2'd0;
        set_in(1'b1, 32'h120);
        step();
        chk("resume_count", 32'(count), 32'd7);

        // Drain in pairs; 0x120 must directly follow 0x11C (0x900 dropped).
        set_in(1'b0, 32'd0);
        deq_num = 2'd2;
        step();
        chk("drain_pc0_a", out_pc0, 32'h110);
        step();
        chk("drain_pc0_b", out_pc0, 32'h118);
        chk("drain_pc1_b", out_pc1, 32'h11C);
        step();
        chk("drain_pc0_c", out_pc0,      32'h120);
        chk("drain_cnt_c", 32'(count),   32'd1);
        chk("drain_v1_c",  32'(out_valid1), 32'd0);
        step();
        chk("drain_cnt_d", 32'(count), 32'd0);
        deq_num = 2'd0;

        // ---- Wrap-around: pointers start at 9 ----
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h200 + 32'(4 * i));
            deq_num = (i >= 4) ? 2'd1 : 2'd0;
            step();
            chk("wrap_pc0", out_pc0, (i < 4) ? 32'h200 : 32'h200 + 32'(4 * (i - 3)));
            if (out_valid1)
                chk("wrap_pc1", out_pc1, out_pc0 + 32'd4);
        end
        chk("wrap_count", 32'(count), 32'd4);
        set_in(1'b0, 32'd0);
        deq_num = 2'd2;
        step();
        chk("wrap_drain_pc0", out_pc0, 32'h248);
        step();
        chk("wrap_drain_cnt", 32'(count), 32'd0);

        // ---- Clamp on over-request ----
        deq_num = 2'd0;
        set_in(1'b1, 32'h300);
        step();
        chk("clamp_pre_count", 32'(count), 32'd1);
        set_in(1'b0, 32'd0);
        deq_num = 2'd2;
        step();
        chk("clamp2_count", 32'(count),      32'd0);
        chk("clamp2_v0",    32'(out_valid0), 32'd0);
        deq_num = 2'd0;
        set_in(1'b1, 32'h304);
        step();
        set_in(1'b0, 32'd0);
        deq_num = 2'd3;
        step();
        chk("clamp3_count", 32'(count),    32'd0);
        chk("clamp3_ready", 32'(in_ready), 32'd1);
        deq_num = 2'd0;
        set_in(1'b1, 32'h308);
        step();
        chk("clamp_after_count", 32'(count), 32'd1);
        chk("clamp_after_pc0",   out_pc0,    32'h308);
        set_in(1'b0, 32'd0);
        deq_num = 2'd1;
        step();
        chk("clamp_final_count", 32'(count), 32'd0);
        deq_num = 2'd0;

        // ---- Flush at count 5 with enqueue and dequeue offered ----
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h400 + 32'(4 * i));
            step();
        end
        chk("flush_pre_count", 32'(count), 32'd5);
        flush   = 1'b1;
        deq_num = 2'd2;
        set_in(1'b1, 32'h500);
        step();
        flush   = 1'b0;
        deq_num = 2'd0;
        set_in(1'b0, 32'd0);
        chk("flush_count", 32'(count),      32'd0);
        chk("flush_v0",    32'(out_valid0), 32'd0);
        chk("flush_ready", 32'(in_ready),   32'd1);
        step();
        chk("flush_hold_count", 32'(count), 32'd0);
        set_in(1'b1, 32'h600);
        step();
        set_in(1'b0, 32'd0);
        chk("post_flush_count", 32'(count),      32'd1);
        chk("post_flush_pc0",   out_pc0,         32'h600);
        chk("post_flush_v1",    32'(out_valid1), 32'd0);

        // ---- Asynchronous reset mid-cycle ----
        set_in(1'b1, 32'h700);
        step();
        set_in(1'b0, 32'd0);
        chk("async_pre_count", 32'(count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_count", 32'(count),      32'd0);
        chk("async_v0",    32'(out_valid0), 32'd0);
        chk("async_pc0",   out_pc0,         32'd0);
        step();
        resetn = 1'b1;
        step();
        chk("async_after_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
